// File: rtl/prefetch_fetcher_if.sv
// rtl/prefetch_fetcher_if.sv - memory port bundle between the prefetch fetcher and instruction memory
//
// One read-only request channel: the fetcher raises mem_ready with mem_addr
// and holds both until the memory answers with mem_valid/mem_rdata.

interface prefetch_fetcher_if;
  logic        mem_ready;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic        mem_valid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_ready,
    output mem_instr,
    output mem_addr,
    output mem_wstrb,
    input  mem_valid,
    input  mem_rdata
  );

  modport slave (
    input  mem_ready,
    input  mem_instr,
    input  mem_addr,
    input  mem_wstrb,
    output mem_valid,
    output mem_rdata
  );
endinterface

// File: rtl/prefetch_fetcher.sv
// rtl/prefetch_fetcher.sv - prefetching instruction fetch unit with a DEPTH-entry queue
//
// Runs ahead of the decoder with one outstanding memory read at a time.
// A queue slot is reserved when a read is issued, so the queue cannot
// overflow. A redirect flushes the queue; a read that is still on the bus
// when the redirect arrives is left to finish and its data is thrown away.

module prefetch_fetcher #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 redirect,
  input  logic [31:0]          redirect_pc,
  input  logic                 decoder_ready,
  output logic                 fetcher_valid,
  output logic [31:0]          instr,
  output logic [31:0]          fetcher_pc,
  prefetch_fetcher_if.master   mem
);

  localparam int             CW      = $clog2(DEPTH + 1);
  localparam int             PW      = $clog2(DEPTH);
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

  // IDLE: no read on the bus. FETCH: read whose data will be queued.
  // DROP: read still on the bus after a redirect; its data is discarded.
  typedef enum logic [1:0] {
    BUS_IDLE  = 2'd0,
    BUS_FETCH = 2'd1,
    BUS_DROP  = 2'd2
  } bus_state_t;

  bus_state_t         state;
  bus_state_t         state_next;

  logic [CW-1:0]      count;
  logic [PW-1:0]      rd_ptr;
  logic [PW-1:0]      wr_ptr;
  logic [31:0]        fetch_pc;
  logic [31:0]        addr_q;

  logic [31:0]        fifo_instr [DEPTH];
  logic [31:0]        fifo_pc    [DEPTH];

  logic               complete;
  logic               issue;
  logic               enq;
  logic               deq;

  // Bus state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= BUS_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Bus next-state plus issue/enqueue/dequeue decode for this cycle
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    enq        = 1'b0;
    complete   = (state != BUS_IDLE) && mem.mem_valid;
    deq        = fetcher_valid && decoder_ready && !redirect;
    case (state)
      BUS_IDLE: begin
        if (!redirect && (count < DEPTH_C)) begin
          issue      = 1'b1;
          state_next = BUS_FETCH;
        end
      end
      BUS_FETCH: begin
        if (complete) begin
          enq        = !redirect;
          state_next = BUS_IDLE;
        end else if (redirect) begin
          state_next = BUS_DROP;
        end
      end
      BUS_DROP: begin
        if (complete) begin
          state_next = BUS_IDLE;
        end
      end
      default: begin
        state_next = BUS_IDLE;
      end
    endcase
  end

  // Queue occupancy, pointers, fetch PC and the held request address
  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fetch_pc <= RESET_PC;
      addr_q   <= '0;
    end else if (redirect) begin
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
    end else begin
      if (issue) begin
        addr_q <= fetch_pc;
      end
      if (enq) begin
        wr_ptr   <= wr_ptr + 1'b1;
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (deq) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Queue storage; entries are only read while counted as valid
  always_ff @(posedge clk) begin
    if (enq && !reset) begin
      fifo_instr[wr_ptr] <= mem.mem_rdata;
      fifo_pc[wr_ptr]    <= addr_q;
    end
  end

  assign fetcher_valid = (count != '0);
  assign instr         = fetcher_valid ? fifo_instr[rd_ptr] : 32'h0;
  assign fetcher_pc    = fetcher_valid ? fifo_pc[rd_ptr]    : 32'h0;

  assign mem.mem_ready = (state != BUS_IDLE);
  assign mem.mem_instr = (state != BUS_IDLE);
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wstrb = 4'b0000;

endmodule

// File: tb/tb_prefetch_fetcher.sv
// tb/tb_prefetch_fetcher.sv - randomized bench for prefetch_fetcher with a queue-level reference model

module tb_prefetch_fetcher;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        decoder_ready;
  logic        fetcher_valid;
  logic [31:0] instr;
  logic [31:0] fetcher_pc;

  prefetch_fetcher_if bus ();

  prefetch_fetcher #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .decoder_ready (decoder_ready),
    .fetcher_valid (fetcher_valid),
    .instr         (instr),
    .fetcher_pc    (fetcher_pc),
    .mem           (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // reference model: queue of {instr, pc}, one optional outstanding read
  logic [63:0] m_q[$];
  bit          m_pending = 1'b0;
  bit          m_drop    = 1'b0;
  logic [31:0] m_pc      = RESET_PC;
  logic [31:0] m_addr    = 32'h0;

  // memory responder state
  logic [31:0] req_log[$];
  bit          prev_ready  = 1'b0;
  int          lat         = 0;
  int          max_lat     = 0;
  bit          spurious_en = 1'b0;
  bit          stall_en    = 1'b0;
  logic [31:0] stall_addr  = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // one clock: apply inputs and the memory response, then step past the edge
  task automatic tick(input logic rd, input logic [31:0] rpc, input logic dr, input logic fv);
    redirect      = rd;
    redirect_pc   = rpc;
    decoder_ready = dr;
    if (bus.mem_ready && !prev_ready) begin
      req_log.push_back(bus.mem_addr);
      lat = $urandom_range(0, max_lat);
    end
    if (bus.mem_ready) begin
      if (fv) bus.mem_valid = 1'b1;
      else if (stall_en && bus.mem_addr == stall_addr) bus.mem_valid = 1'b0;
      else if (lat == 0) bus.mem_valid = 1'b1;
      else begin
        bus.mem_valid = 1'b0;
        lat--;
      end
    end else begin
      bus.mem_valid = spurious_en && ($urandom_range(0, 7) == 0);
    end
    bus.mem_rdata = $urandom();
    prev_ready    = bus.mem_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    reset = 1'b0;
    req_log.delete();
    chk_en = 1'b1;
  endtask

  // compare DUT against the model, then advance the model by this cycle's inputs
  initial begin
    bit complete;
    int occ;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("fetcher_valid", {31'h0, fetcher_valid}, {31'h0, (m_q.size() != 0)});
        if (m_q.size() != 0) begin
          check("instr", instr, m_q[0][63:32]);
          check("fetcher_pc", fetcher_pc, m_q[0][31:0]);
        end
        check("mem_ready", {31'h0, bus.mem_ready}, {31'h0, m_pending});
        check("mem_instr", {31'h0, bus.mem_instr}, {31'h0, m_pending});
        if (m_pending) check("mem_addr", bus.mem_addr, m_addr);
        check("mem_wstrb", {28'h0, bus.mem_wstrb}, 32'h0);
      end
      if (reset) begin
        m_q.delete();
        m_pending = 1'b0;
        m_drop    = 1'b0;
        m_pc      = RESET_PC;
        m_addr    = 32'h0;
      end else begin
        complete = m_pending && bus.mem_valid;
        occ      = m_q.size();
        if (redirect) begin
          m_q.delete();
          if (m_pending && !complete) m_drop = 1'b1;
          else begin
            m_pending = 1'b0;
            m_drop    = 1'b0;
          end
          m_pc = redirect_pc & 32'hFFFF_FFFC;
        end else begin
          if (occ != 0 && decoder_ready) void'(m_q.pop_front());
          if (complete) begin
            if (!m_drop) begin
              m_q.push_back({bus.mem_rdata, m_addr});
              m_pc = m_pc + 32'd4;
            end
            m_pending = 1'b0;
            m_drop    = 1'b0;
          end else if (!m_pending && occ < DEPTH) begin
            m_pending = 1'b1;
            m_addr    = m_pc;
          end
        end
      end
    end
  end

  initial begin
    int base;
    reset         = 1'b1;
    redirect      = 1'b0;
    redirect_pc   = 32'h0;
    decoder_ready = 1'b0;
    bus.mem_valid = 1'b0;
    bus.mem_rdata = 32'h0;

    // sequential fetch, decoder always ready
    do_reset();
    check("rst_mem_ready", {31'h0, bus.mem_ready}, 32'h0);
    check("rst_fetcher_valid", {31'h0, fetcher_valid}, 32'h0);
    for (int i = 0; i < 20; i++) tick(1'b0, 32'h0, 1'b1, 1'b0);
    check("seq_req_count_ge3", {31'h0, (req_log.size() >= 3)}, 32'h1);
    if (req_log.size() >= 3) begin
      check("seq_addr0", req_log[0], 32'h0);
      check("seq_addr1", req_log[1], 32'h4);
      check("seq_addr2", req_log[2], 32'h8);
    end

    // decoder stalled: queue fills to DEPTH, then drains and fetch resumes
    do_reset();
    for (int i = 0; i < 30; i++) tick(1'b0, 32'h0, 1'b0, 1'b0);
    check("full_req_count", req_log.size(), 32'd4);
    if (req_log.size() == 4) check("full_last_addr", req_log[3], 32'hC);
    check("full_mem_ready", {31'h0, bus.mem_ready}, 32'h0);
    check("full_valid", {31'h0, fetcher_valid}, 32'h1);
    for (int i = 0; i < 40 && req_log.size() < 5; i++) tick(1'b0, 32'h0, 1'b1, 1'b0);
    check("resume_req_count", req_log.size(), 32'd5);
    if (req_log.size() == 5) check("resume_addr", req_log[4], 32'h10);

    // redirect while the read to 0x8 is outstanding
    do_reset();
    stall_en   = 1'b1;
    stall_addr = 32'h8;
    for (int i = 0; i < 40 && !(bus.mem_ready && bus.mem_addr == 32'h8); i++) tick(1'b0, 32'h0, 1'b1, 1'b0);
    check("rd_wait_8", {31'h0, (bus.mem_ready && bus.mem_addr == 32'h8)}, 32'h1);
    tick(1'b1, 32'h0000_1003, 1'b1, 1'b0);
    tick(1'b0, 32'h0, 1'b1, 1'b0);
    tick(1'b0, 32'h0, 1'b1, 1'b0);
    stall_en = 1'b0;
    base = req_log.size();
    for (int i = 0; i < 40 && req_log.size() <= base; i++) tick(1'b0, 32'h0, 1'b0, 1'b0);
    check("rd_new_req", {31'h0, (req_log.size() > base)}, 32'h1);
    if (req_log.size() > base) check("rd_new_addr", req_log[base], 32'h1000);
    for (int i = 0; i < 40 && !fetcher_valid; i++) tick(1'b0, 32'h0, 1'b0, 1'b0);
    check("rd_first_pc", fetcher_pc, 32'h1000);

    // redirect coinciding with completion and dequeue, two entries queued
    do_reset();
    stall_en   = 1'b1;
    stall_addr = 32'h8;
    for (int i = 0; i < 40 && !(bus.mem_ready && bus.mem_addr == 32'h8); i++) tick(1'b0, 32'h0, 1'b0, 1'b0);
    check("rc_model_depth2", m_q.size(), 32'd2);
    check("rc_valid_before", {31'h0, fetcher_valid}, 32'h1);
    tick(1'b1, 32'h0000_2000, 1'b1, 1'b1);
    stall_en = 1'b0;
    check("rc_valid_after", {31'h0, fetcher_valid}, 32'h0);
    base = req_log.size();
    for (int i = 0; i < 40 && req_log.size() <= base; i++) tick(1'b0, 32'h0, 1'b1, 1'b0);
    if (req_log.size() > base) check("rc_new_addr", req_log[base], 32'h2000);
    else check("rc_new_req", 32'h0, 32'h1);

    // fetch PC wraps past the top of the address space
    tick(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0);
    base = req_log.size();
    for (int i = 0; i < 40 && req_log.size() < base + 2; i++) tick(1'b0, 32'h0, 1'b1, 1'b0);
    if (req_log.size() >= base + 2) begin
      check("wrap_addr_hi", req_log[base], 32'hFFFF_FFFC);
      check("wrap_addr_zero", req_log[base + 1], 32'h0);
    end else begin
      check("wrap_req_count", req_log.size(), base + 2);
    end

    // reset asserted while a read is outstanding
    do_reset();
    stall_en   = 1'b1;
    stall_addr = 32'h4;
    for (int i = 0; i < 40 && !(bus.mem_ready && bus.mem_addr == 32'h4); i++) tick(1'b0, 32'h0, 1'b0, 1'b0);
    check("mr_wait_4", {31'h0, bus.mem_ready}, 32'h1);
    reset = 1'b1;
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    reset = 1'b0;
    stall_en = 1'b0;
    req_log.delete();
    check("mr_mem_ready", {31'h0, bus.mem_ready}, 32'h0);
    check("mr_mem_instr", {31'h0, bus.mem_instr}, 32'h0);
    check("mr_mem_addr", bus.mem_addr, 32'h0);
    check("mr_valid", {31'h0, fetcher_valid}, 32'h0);
    check("mr_instr", instr, 32'h0);
    check("mr_pc", fetcher_pc, 32'h0);
    for (int i = 0; i < 10 && req_log.size() == 0; i++) tick(1'b0, 32'h0, 1'b1, 1'b0);
    if (req_log.size() != 0) check("mr_first_addr", req_log[0], RESET_PC);
    else check("mr_first_req", 32'h0, 32'h1);

    // randomized traffic against the model
    max_lat     = 3;
    spurious_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 599) == 0);
      tick(($urandom_range(0, 19) == 0), $urandom(), (i % 200 < 150) ? ($urandom_range(0, 3) != 0) : 1'b0, 1'b0);
    end
    reset = 1'b0;
    tick(1'b0, 32'h0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
